// File: rtl/bfly20_stage.sv
// Radix-2 SDF butterfly stage: pairs beat b with beat b+DIST_BEATS in each group and streams sums then differences.
// Optional macro BFLY20_SCALE_EN: each sum/difference is halved with round-half-up.
module bfly20_stage #(
    parameter int WIDTH       = 13,
    parameter int LANES       = 16,
    parameter int DIST_BEATS  = 4,
    parameter int FRAME_BEATS = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-2:0] in_re [0:LANES-1],
    input  logic signed [WIDTH-2:0] in_im [0:LANES-1],
    output logic                    o_valid,
    output logic                    o_last,
    output logic signed [WIDTH-1:0] o_re [0:LANES-1],
    output logic signed [WIDTH-1:0] o_im [0:LANES-1]
);
    localparam int GRP_BEATS = 2 * DIST_BEATS;
    localparam int GW = $clog2(GRP_BEATS);
    localparam int FW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int DW = (DIST_BEATS > 1) ? $clog2(DIST_BEATS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_BFLY  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]    st_reg, st_next;
    logic [GW-1:0] grp_reg, grp_next;
    logic [FW-1:0] frm_reg, frm_next;
    logic [DW-1:0] drn_reg;
    logic          dif_vld_reg, rdy_reg, valid_reg, last_reg;
    logic          accept, draining, in_fill, grp_last, frm_last, drn_last;

    // dly_*[0] is the newest entry, dly_*[DIST_BEATS-1] is the head popped each shift.
    logic signed [WIDTH-1:0] dly_re [0:DIST_BEATS-1][0:LANES-1];
    logic signed [WIDTH-1:0] dly_im [0:DIST_BEATS-1][0:LANES-1];
    logic signed [WIDTH-1:0] ext_re [0:LANES-1];
    logic signed [WIDTH-1:0] ext_im [0:LANES-1];
    logic signed [WIDTH-1:0] sum_re [0:LANES-1];
    logic signed [WIDTH-1:0] sum_im [0:LANES-1];
    logic signed [WIDTH-1:0] dif_re [0:LANES-1];
    logic signed [WIDTH-1:0] dif_im [0:LANES-1];

    assign in_ready = rdy_reg;
    assign o_valid  = valid_reg;
    assign o_last   = last_reg;
    assign accept   = in_valid && rdy_reg;
    assign draining = (st_reg == ST_DRAIN);
    assign in_fill  = (grp_reg < GW'(DIST_BEATS));
    assign grp_last = (grp_reg == GW'(GRP_BEATS - 1));
    assign frm_last = (frm_reg == FW'(FRAME_BEATS - 1));
    assign drn_last = (drn_reg == DW'(DIST_BEATS - 1));
    assign grp_next = grp_last ? '0 : grp_reg + GW'(1);
    assign frm_next = frm_last ? '0 : frm_reg + FW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [WIDTH-1:0] a_re, a_im;
            assign a_re       = dly_re[DIST_BEATS-1][gi];
            assign a_im       = dly_im[DIST_BEATS-1][gi];
            assign ext_re[gi] = {in_re[gi][WIDTH-2], in_re[gi]};
            assign ext_im[gi] = {in_im[gi][WIDTH-2], in_im[gi]};
`ifdef BFLY20_SCALE_EN
            logic signed [WIDTH:0] s_re, s_im, d_re, d_im;
            assign s_re = {a_re[WIDTH-1], a_re} + {ext_re[gi][WIDTH-1], ext_re[gi]};
            assign s_im = {a_im[WIDTH-1], a_im} + {ext_im[gi][WIDTH-1], ext_im[gi]};
            assign d_re = {a_re[WIDTH-1], a_re} - {ext_re[gi][WIDTH-1], ext_re[gi]};
            assign d_im = {a_im[WIDTH-1], a_im} - {ext_im[gi][WIDTH-1], ext_im[gi]};
            // Extra bit keeps s+1 exact before the arithmetic halving.
            assign sum_re[gi] = WIDTH'((s_re + (WIDTH+1)'(1)) >>> 1);
            assign sum_im[gi] = WIDTH'((s_im + (WIDTH+1)'(1)) >>> 1);
            assign dif_re[gi] = WIDTH'((d_re + (WIDTH+1)'(1)) >>> 1);
            assign dif_im[gi] = WIDTH'((d_im + (WIDTH+1)'(1)) >>> 1);
`else
            assign sum_re[gi] = a_re + ext_re[gi];
            assign sum_im[gi] = a_im + ext_im[gi];
            assign dif_re[gi] = a_re - ext_re[gi];
            assign dif_im[gi] = a_im - ext_im[gi];
`endif
        end
    endgenerate

    always_comb begin
        st_next = st_reg;
        if (draining) begin
            if (drn_last) st_next = ST_IDLE;
        end else if (accept) begin
            if (frm_last)                            st_next = ST_DRAIN;
            else if (grp_next < GW'(DIST_BEATS))     st_next = ST_FILL;
            else                                     st_next = ST_BFLY;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_reg      <= ST_IDLE;
            grp_reg     <= '0;
            frm_reg     <= '0;
            drn_reg     <= '0;
            dif_vld_reg <= 1'b0;
            rdy_reg     <= 1'b0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
        end else begin
            st_reg    <= st_next;
            rdy_reg   <= (st_next != ST_DRAIN);
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            if (accept) begin
                grp_reg <= grp_next;
                frm_reg <= frm_next;
                if (in_fill) begin
                    valid_reg <= dif_vld_reg;
                end else begin
                    valid_reg <= 1'b1;
                    if (grp_last) dif_vld_reg <= 1'b1;
                end
            end else if (draining) begin
                valid_reg <= 1'b1;
                drn_reg   <= drn_last ? '0 : drn_reg + DW'(1);
                if (drn_last) begin
                    last_reg    <= 1'b1;
                    dif_vld_reg <= 1'b0;
                end
            end
        end
    end

    // Head is read before the shift overwrites it, so pop and push share one edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int l = 0; l < LANES; l++) begin
                o_re[l] <= '0;
                o_im[l] <= '0;
                for (int d = 0; d < DIST_BEATS; d++) begin
                    dly_re[d][l] <= '0;
                    dly_im[d][l] <= '0;
                end
            end
        end else if (accept || draining) begin
            for (int l = 0; l < LANES; l++) begin
                if (accept && !in_fill) begin
                    o_re[l]      <= sum_re[l];
                    o_im[l]      <= sum_im[l];
                    dly_re[0][l] <= dif_re[l];
                    dly_im[0][l] <= dif_im[l];
                end else begin
                    o_re[l]      <= dly_re[DIST_BEATS-1][l];
                    o_im[l]      <= dly_im[DIST_BEATS-1][l];
                    dly_re[0][l] <= accept ? ext_re[l] : '0;
                    dly_im[0][l] <= accept ? ext_im[l] : '0;
                end
                for (int d = 1; d < DIST_BEATS; d++) begin
                    dly_re[d][l] <= dly_re[d-1][l];
                    dly_im[d][l] <= dly_im[d-1][l];
                end
            end
        end
    end

endmodule

// File: doc/bfly20_stage.md
Name: bfly20_stage

Overview:
- Radix-2 SDF butterfly stage of the 512-point streaming FFT. It sits directly upstream of the stage-20 trivial-twiddle multiplier and feeds it.
- Consumes 16 samples per beat and pairs beat b with beat b+DIST_BEATS inside each group of 2*DIST_BEATS beats.
- Emits sums, then buffered differences, in natural group order with 1-bit growth.
- Its o_valid drives the downstream twd20_valid.

Parameters:
- WIDTH, 13: output sample width (signed); inputs are WIDTH-1 bits.
- LANES, 16: samples per beat.
- DIST_BEATS, 4: butterfly distance in beats (64 samples at default).
- FRAME_BEATS, 32: beats per frame (512/16). Must be a multiple of 2*DIST_BEATS.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_re[0:LANES-1]  in  WIDTH-1 each, signed  real inputs
- in_im[0:LANES-1]  in  WIDTH-1 each, signed  imag inputs
- o_valid  out  1  output beat valid (drives twd20_valid)
- o_last  out  1  last output beat of a frame
- o_re[0:LANES-1]  out  WIDTH each, signed  real outputs
- o_im[0:LANES-1]  out  WIDTH each, signed  imag outputs

Behaviour:
- Reset: rstn is asynchronous and active-low; clock is clk. On reset all outputs are 0 (o_valid, o_last, o_re, o_im). Buffer, counters and flags clear; state is IDLE; in_ready=1 one cycle after reset release.
- Handshake: a beat is accepted on a clk edge when in_valid && in_ready. in_valid may drop at any time; state advances only on accepted beats, except in DRAIN.
- Counters: grp_cnt 0..2*DIST_BEATS-1 and frm_cnt 0..FRAME_BEATS-1 both increment per accepted beat and wrap to 0.
- Buffer: DIST_BEATS-deep shift register of LANES complex WIDTH-bit words. It shifts by one entry per accepted beat and per DRAIN cycle. Read happens before write within the same cycle.
- FILL phase (grp_cnt < DIST_BEATS):
  - Input is sign-extended to WIDTH and pushed into the buffer.
  - If the buffer holds differences (flag dif_vld), the popped entry is registered to the outputs with o_valid=1.
  - Otherwise o_valid=0.
- BFLY phase (grp_cnt >= DIST_BEATS):
  - With buffer head a and input b: o = a+b registered, o_valid=1. a-b is pushed into the buffer.
  - dif_vld is set on the last BFLY beat.
- Arithmetic: sign-extend both operands to WIDTH; no saturation is needed. Worst cases are -2048 + -2048 = -4096 and -2048 - 2047 = -4095.
- Latency: each output appears 1 clock after its triggering accept (registered outputs).
- States:
  - IDLE: enter FILL on first accept.
  - FILL / BFLY: selected by grp_cnt.
  - Enter DRAIN on the accept with frm_cnt = FRAME_BEATS-1.
  - DRAIN: in_ready=0. Pops one difference per clock for DIST_BEATS consecutive clocks, o_valid=1 each. o_last=1 on the final pop. Then return to IDLE and clear dif_vld.
- Frame output: exactly FRAME_BEATS output beats in order S0, D0, S1, D1, ...
- o_valid pulses are single-cycle per beat; o_valid=0 on cycles with no accept outside DRAIN.
- in_ready is 1 in IDLE, FILL and BFLY; 0 only in DRAIN.
- Back-to-back frames: a new frame is accepted from the first cycle after DRAIN ends.
- Reset mid-frame: all in-flight data is discarded, no partial output, outputs return to 0 immediately.

Optional Feature:
- Macro: BFLY20_SCALE_EN.
- Defined: each sum/difference s (WIDTH bits) is output as (s+1)>>>1 (round half up), sign-kept at WIDTH bits. Applies to both the sum path and the difference path at buffer-write time.
- Undefined: full-precision results, no scaling.

Test Plan:
- Single frame, all lanes: beats 0-3 re=100 im=-5, beats 4-7 re=20 im=5. Expect outputs 1 clk after beats 4-7 = (120,0) ×4; diffs (80,-10) ×4 on the accepts of beats 8-11.
- Extremes: first-half re=-2048, second-half re=-2048 -> sum -4096; second half re=2047 -> diff -4095; no wrap at WIDTH=13.
- Drain: after accept of beat 31, in_ready=0 for exactly 4 clocks. o_valid high 4 consecutive clocks with the group-3 diffs; o_last=1 only on the 4th; in_ready=1 after.
- Gapped input: in_valid toggling 1-0-1 across a frame. Output values identical to the gapless run; o_valid=0 on gap cycles; 32 output beats total.
- Reset: assert rstn=0 at beat 13. Outputs 0 immediately; a new full frame after release matches a clean run.
- With BFLY20_SCALE_EN: 100+20 -> 60; 3+0 -> 2; -3+0 -> -1; 100-20 -> 40.
